// File: rtl/mux2_arbiter_pkg.sv
// mux2_arbiter_pkg: state encoding and hold-counter width helper for the 2:1 mux arbiter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    function automatic int hold_w(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/mux2_arb_fsm.sv
// mux2_arb_fsm: round-robin grant FSM with hold timeout; all outputs registered.
module mux2_arb_fsm
    import mux2_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic valid,
    output logic preempt
);
    localparam int HOLD_W = hold_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
    localparam bit PRE_EN = MAX_HOLD != 0;

    state_t state, nxt, oth_st;
    logic last, own, oth, pre, gx;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;

    assign gx = state == G1;
    assign own = gx ? req1 : req0;
    assign oth = gx ? req0 : req1;
    assign oth_st = gx ? G0 : G1;

    always_comb begin
        nxt = state;
        pre = 1'b0;
        if (state == IDLE) begin
            nxt = (req0 && (!req1 || last)) ? G0 : (req1 ? G1 : IDLE);
        end else if (!own) begin
            nxt = oth ? oth_st : IDLE;
        end else if (oth && PRE_EN && hold_cnt == HOLD_TOP) begin
            nxt = oth_st;
            pre = 1'b1;
        end
        // Count only while the other side waits under an unchanged grant.
        hold_nxt = (nxt != state || nxt == IDLE || !oth) ? '0 :
                   (hold_cnt == HOLD_TOP) ? hold_cnt : hold_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            s        <= 1'b0;
            valid    <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= nxt;
            hold_cnt <= hold_nxt;
            gnt0     <= nxt == G0;
            gnt1     <= nxt == G1;
            valid    <= (nxt == G0) || (nxt == G1);
            s        <= (nxt == G1) ? 1'b1 : (nxt == G0) ? 1'b0 : s;
            last     <= (nxt == G1) ? 1'b1 : (nxt == G0) ? 1'b0 : last;
            preempt  <= pre;
        end
    end
endmodule

// File: rtl/mux_2x1.sv
// mux_2x1: single-bit 2:1 selector cell (sel=0 -> a, sel=1 -> b).
module mux_2x1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: fair round-robin sharing of a 2:1 data mux between two requesters.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             s,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             preempt
);
    mux2_arb_fsm #(.MAX_HOLD(MAX_HOLD)) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .s       (s),
        .valid   (valid),
        .preempt (preempt)
    );

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        mux_2x1 u_mux (
            .a   (d0[b]),
            .b   (d1[b]),
            .sel (s),
            .y   (result[b])
        );
    end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: scoreboard bench for two arbiter instances (MAX_HOLD=4 and MAX_HOLD=0).
module tb_mux2_arbiter;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic [W-1:0] d0 = '0;
    logic [W-1:0] d1 = '0;

    logic gnt0_a, gnt1_a, s_a, valid_a, preempt_a;
    logic gnt0_b, gnt1_b, s_b, valid_b, preempt_b;
    logic [W-1:0] result_a, result_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0_a), .gnt1(gnt1_a), .s(s_a), .result(result_a),
        .valid(valid_a), .preempt(preempt_a)
    );

    mux2_arbiter #(.WIDTH(W), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .result(result_b),
        .valid(valid_b), .preempt(preempt_b)
    );

    // Reference model: owner (-1 = none), last owner, cycles held while the other waits.
    int own[2] = '{-1, -1};
    int lst[2] = '{1, 1};
    int held[2] = '{0, 0};
    int sel[2] = '{0, 0};
    int mh[2] = '{4, 0};
    int r[2];
    bit m_pre;
    logic [W+4:0] exp_v;
    logic [W+4:0] q0[$];
    logic [W+4:0] q1[$];

    always @(posedge clk) begin
        r[0] = int'(req0);
        r[1] = int'(req1);
        for (int k = 0; k < 2; k++) begin
            m_pre = 1'b0;
            if (reset) begin
                own[k] = -1; lst[k] = 1; held[k] = 0; sel[k] = 0;
            end else if (own[k] < 0) begin
                held[k] = 0;
                if (r[0] != 0 && r[1] != 0) own[k] = 1 - lst[k];
                else if (r[0] != 0) own[k] = 0;
                else if (r[1] != 0) own[k] = 1;
            end else begin
                int o;
                o = own[k];
                if (r[o] == 0) begin
                    own[k] = (r[1-o] != 0) ? 1 - o : -1;
                    held[k] = 0;
                end else if (r[1-o] != 0) begin
                    held[k]++;
                    if (mh[k] > 0 && held[k] == mh[k]) begin
                        own[k] = 1 - o;
                        held[k] = 0;
                        m_pre = 1'b1;
                    end
                end else begin
                    held[k] = 0;
                end
            end
            if (own[k] >= 0) begin
                lst[k] = own[k];
                sel[k] = own[k];
            end
            exp_v = {own[k] == 0, own[k] == 1, sel[k] == 1, own[k] >= 0, m_pre,
                     (sel[k] == 1) ? d1 : d0};
            if (k == 0) q0.push_back(exp_v);
            else q1.push_back(exp_v);
        end
    end

    logic [W+4:0] got_a, got_b, e;
    assign got_a = {gnt0_a, gnt1_a, s_a, valid_a, preempt_a, result_a};
    assign got_b = {gnt0_b, gnt1_b, s_b, valid_b, preempt_b, result_b};

    always @(posedge clk) begin
        #1;
        checks++;
        if (q0.size() == 0) begin
            errors++;
            $display("FAIL mh4_outputs: got %h, required an expectation but queue empty", got_a);
        end else begin
            e = q0.pop_front();
            if (got_a !== e) begin
                errors++;
                $display("FAIL mh4_outputs t=%0t: got {g0,g1,s,v,pre,res}=%h required %h", $time, got_a, e);
            end
        end
        checks++;
        if (q1.size() == 0) begin
            errors++;
            $display("FAIL mh0_outputs: got %h, required an expectation but queue empty", got_b);
        end else begin
            e = q1.pop_front();
            if (got_b !== e) begin
                errors++;
                $display("FAIL mh0_outputs t=%0t: got {g0,g1,s,v,pre,res}=%h required %h", $time, got_b, e);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        d0 = 8'hA5;
        d1 = 8'h3C;
        cycles(2);
        reset = 1'b0;
        cycles(5);
        req0 = 1'b1;
        cycles(3);
        req0 = 1'b0;
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        cycles(1);
        req0 = 1'b0;
        cycles(1);
        req1 = 1'b0;
        cycles(3);
        req0 = 1'b1;
        req1 = 1'b1;
        cycles(20);
        req0 = 1'b0;
        cycles(4);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({gnt0_a, gnt1_a, s_a, valid_a, preempt_a} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_mh4: got %b required 00000", {gnt0_a, gnt1_a, s_a, valid_a, preempt_a});
        end
        checks++;
        if ({gnt0_b, gnt1_b, s_b, valid_b, preempt_b} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset_mh0: got %b required 00000", {gnt0_b, gnt1_b, s_b, valid_b, preempt_b});
        end
        req0 = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(12);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) req0 = ~req0;
            if ($urandom_range(3) == 0) req1 = ~req1;
            d0 = W'($urandom);
            d1 = W'($urandom);
            if ($urandom_range(150) == 0) reset = 1'b1;
            else reset = 1'b0;
            cycles(1);
        end
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
